// File: rtl/vram_arbiter.sv
// Framebuffer RAM arbiter: VGA display fetch owns active video, two writers share the rest round-robin.
// Build macro VRAM_SHARE_ACTIVE_EN: display reads once per 2**PIX_SHIFT pixels, writers use the other active cycles.
module vram_arbiter #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 8,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int PIX_SHIFT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          x_coord,
  input  logic [9:0]          y_coord,
  input  logic [1:0]          wr_req,
  input  logic [2*ADDR_W-1:0] wr_addr,
  input  logic [2*DATA_W-1:0] wr_data,
  output logic [1:0]          wr_gnt,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [DATA_W-1:0]   pixel_data,
  output logic                pixel_valid,
  output logic                frame_tick
);
  localparam int          FB_W    = H_ACTIVE >> PIX_SHIFT;
  localparam int          FB_H    = V_ACTIVE >> PIX_SHIFT;
  localparam logic [31:0] FB_SIZE = 32'(FB_W * FB_H);
  localparam logic [9:0]  H_ACT_C = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT_C = 10'(V_ACTIVE);

  logic              active_s;
  logic              disp_rd_s;
  logic [ADDR_W-1:0] disp_addr_s;
  logic [ADDR_W-1:0] w_addr_s [2];
  logic [DATA_W-1:0] w_data_s [2];
  logic [1:0]        in_range_s;

  logic              ptr_q, ptr_d;
  logic              act_d1_q, rd_d1_q;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic              pix_valid_q;
  logic              frame_tick_q;

  assign active_s    = (x_coord < H_ACT_C) && (y_coord < V_ACT_C);
  assign disp_addr_s = ADDR_W'(32'(y_coord >> PIX_SHIFT) * 32'(FB_W) + 32'(x_coord >> PIX_SHIFT));

`ifdef VRAM_SHARE_ACTIVE_EN
  assign disp_rd_s = active_s && (x_coord[PIX_SHIFT-1:0] == '0);
`else
  assign disp_rd_s = active_s;
`endif

  // Unpack writer buses; out-of-range writes are still granted but never reach the RAM.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_addr_s[i]   = wr_addr[i*ADDR_W +: ADDR_W];
      w_data_s[i]   = wr_data[i*DATA_W +: DATA_W];
      in_range_s[i] = (32'(w_addr_s[i]) < FB_SIZE);
    end
  end

  // Slot arbitration and RAM port mux.
  always_comb begin
    wr_gnt    = 2'b00;
    ram_we    = 1'b0;
    ram_addr  = disp_addr_s;
    ram_wdata = '0;
    ptr_d     = ptr_q;
    if (rst || disp_rd_s) begin
      wr_gnt = 2'b00;
    end else begin
      case (wr_req)
        2'b01:   wr_gnt = 2'b01;
        2'b10:   wr_gnt = 2'b10;
        2'b11:   wr_gnt = ptr_q ? 2'b10 : 2'b01;
        default: wr_gnt = 2'b00;
      endcase
      if (wr_gnt[0]) begin
        ram_addr  = w_addr_s[0];
        ram_wdata = w_data_s[0];
        ram_we    = in_range_s[0];
        ptr_d     = 1'b1;
      end else if (wr_gnt[1]) begin
        ram_addr  = w_addr_s[1];
        ram_wdata = w_data_s[1];
        ram_we    = in_range_s[1];
        ptr_d     = 1'b0;
      end else begin
        ptr_d = ptr_q;
      end
    end
  end

  // Stage-2 pixel: fresh RAM data after a read, hold between reads inside active video, zero in blanking.
  always_comb begin
    pix_d = '0;
    if (rd_d1_q) begin
      pix_d = ram_rdata;
    end else if (act_d1_q) begin
      pix_d = pix_q;
    end else begin
      pix_d = '0;
    end
  end

  // Round-robin pointer, pixel pipeline and frame tick registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= 1'b0;
      act_d1_q     <= 1'b0;
      rd_d1_q      <= 1'b0;
      pix_q        <= '0;
      pix_valid_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      act_d1_q     <= active_s;
      rd_d1_q      <= disp_rd_s;
      pix_q        <= pix_d;
      pix_valid_q  <= act_d1_q;
      frame_tick_q <= (y_coord == V_ACT_C) && (x_coord == 10'd0);
    end
  end

  assign pixel_data  = pix_q;
  assign pixel_valid = pix_valid_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one synchronous single-port framebuffer RAM between the VGA display fetch and two game-logic writers.
- The display owns the port during active video. Writers are served round-robin in the remaining slots.
- The block takes the pixel coordinates from the VGA timing generator. It returns scaled pixel data to the colour stage and a once-per-frame tick to game logic.

Parameters:
- ADDR_W, 15, RAM address width.
- DATA_W, 8, pixel/RAM data width.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- PIX_SHIFT, 2, framebuffer downscale as log2. FB_W = H_ACTIVE>>PIX_SHIFT (160), FB_H = V_ACTIVE>>PIX_SHIFT (120).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- x_coord  in  10  horizontal coordinate from timing generator; blanking values wrap to large unsigned values
- y_coord  in  10  vertical coordinate, same convention
- wr_req  in  2  per-writer write request
- wr_addr  in  2*ADDR_W  writer addresses; writer i occupies bits [i*ADDR_W +: ADDR_W]
- wr_data  in  2*DATA_W  writer data, same packing
- wr_gnt  out  2  one-hot; the write commits at the clock edge where the bit is high
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address is presented
- pixel_data  out  DATA_W  pixel for the colour stage
- pixel_valid  out  1  pixel_data corresponds to an active pixel
- frame_tick  out  1  one-cycle pulse at start of vertical blank

Behaviour:
- active = (x_coord < H_ACTIVE) && (y_coord < V_ACTIVE), both unsigned compares.
- Display address = (y_coord>>PIX_SHIFT)*FB_W + (x_coord>>PIX_SHIFT), truncated to ADDR_W.
- Display slot: every cycle where active is high, unless the optional feature is enabled.
  - ram_addr = display address, ram_we = 0, wr_gnt = 0.
- Writer slot: every other cycle.
  - Round-robin pointer ptr (1 bit) names the writer with priority.
  - If both requests are high, grant writer ptr. If one is high, grant that one. If none, wr_gnt = 0 and ram_we = 0.
  - ram_addr and ram_wdata come from the granted writer.
  - On a grant to writer i, ptr <= ~i at the edge.
- wr_gnt, ram_we, ram_addr and ram_wdata are combinational from the registered state and the inputs.
- Writer handshake: a writer holds req/addr/data stable until it sees gnt high at an edge. Dropping req before a grant is legal; no write occurs.
- Out-of-range write (wr_addr >= FB_W*FB_H = 19200): the request is granted so it cannot hang, but ram_we is forced to 0 and the write is dropped.
- Pixel pipeline, 2-cycle latency from coordinate to pixel_data:
  - stage 1 registers act_d1 <= active and rd_d1 <= display read issued.
  - stage 2 rule: if rd_d1, pixel_data <= ram_rdata. Else if act_d1, pixel_data holds. Else pixel_data <= 0.
  - pixel_valid <= act_d1.
- frame_tick: registered, high for exactly one cycle after the cycle where y_coord == V_ACTIVE and x_coord == 0.
- Reset: when rst is high, wr_gnt = 0 and ram_we = 0 combinationally. At the edge: ptr=0, act_d1=0, rd_d1=0, pixel_data=0, pixel_valid=0, frame_tick=0.
- Reset mid-write: a request pending at reset is not granted. It is granted normally after release if still requested.
- Coordinates are unconstrained here; the timing generator guarantees monotonic order.

Optional Feature:
- Macro: VRAM_SHARE_ACTIVE_EN.
- Defined: within active video, the display reads only when x_coord[PIX_SHIFT-1:0] == 0. All other active cycles are writer slots (3 of every 4 with default parameters). pixel_data holds the last fetched value between reads per the stage-2 rule.
- Undefined: the display owns every active cycle. Writers are served only in blanking.
- Displayed pixels are identical in both builds.

Test Plan:
- Reset: hold rst with both wr_req=1 -> wr_gnt=00, ram_we=0, pixel_data=0, pixel_valid=0, ptr=0. First blanking cycle after release -> wr_gnt=01.
- Blanking contention: x=650, y=10, wr_req=11 held for 4 cycles -> wr_gnt sequence 01,10,01,10; RAM receives wr_addr0/1 alternately.
- Active lockout, feature off: x=0..639, y=0, wr_req=01 -> wr_gnt=00 throughout. Grant occurs at x=640. Writer 0 at addr 5 data 0x3C lands in RAM.
- Display fetch: RAM preloaded with addr 161 = 0xA5; drive x=4, y=4 -> ram_addr=161, pixel_data=0xA5 and pixel_valid=1 exactly two cycles later.
- Out-of-range: writer 1 requests addr 19200 in blanking -> wr_gnt=10, ram_we=0, RAM unchanged. Next request is served normally.
- frame_tick, plus feature on: y=480, x=0 -> frame_tick high one cycle only. With VRAM_SHARE_ACTIVE_EN, x=1..3 active with wr_req=01 -> grants at x=1,2,3; pixel_data steady at the x=0 value.
